// File: rtl/axis_axil_cmd_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axis_axil_cmd_bridge
//
// Purpose: takes command frames from an 8-bit AXIS byte stream and runs each
// one as a single AXI-Lite master transaction. Read data goes back to the host
// as an AXIS byte frame. Only one command is in flight at a time.
//
// Frame layout: header (bit7 = 1 write / 0 read), ADDR_BYTES address bytes
// MSB first, then for writes DATA_BYTES data bytes MSB first. tlast must be
// on the final byte only. Malformed frames bump frame_err_count (saturating)
// and cause no bus access.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   s_axis_*              command byte stream in (tdest filters, tid echoed)
//   m_axis_*              read response byte stream out (tdest always 0)
//   axil_aw_* / axil_w_*  write address / data channels (master)
//   axil_b_*              write response channel
//   axil_ar_* / axil_r_*  read address / data channels (master)
//   frame_err_count       saturating count of malformed frames
//
// Optional feature: define BRIDGE_TIMEOUT_EN to add a watchdog that gives up
// on a bus phase after TIMEOUT_CYCLES cycles (writes are dropped, reads
// answer with all-ones data). Without it the bridge waits indefinitely.
// -----------------------------------------------------------------------------
module axis_axil_cmd_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [3:0]  DEST_ID        = 4'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic [3:0]                  s_axis_tdest,
  input  logic [1:0]                  s_axis_tid,
  output logic                        s_axis_tready,
  output logic [7:0]                  m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [1:0]                  m_axis_tid,
  output logic [3:0]                  m_axis_tdest,
  input  logic                        m_axis_tready,
  output logic [AXI_ADDR_WIDTH-1:0]   axil_aw_addr,
  output logic                        axil_aw_valid,
  input  logic                        axil_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axil_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axil_w_strb,
  output logic                        axil_w_valid,
  input  logic                        axil_w_ready,
  input  logic                        axil_b_valid,
  output logic                        axil_b_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   axil_ar_addr,
  output logic                        axil_ar_valid,
  input  logic                        axil_ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   axil_r_data,
  input  logic                        axil_r_valid,
  output logic                        axil_r_ready,
  output logic [7:0]                  frame_err_count
);

  localparam int unsigned ADDR_BYTES = AXI_ADDR_WIDTH / 8;
  localparam int unsigned DATA_BYTES = AXI_DATA_WIDTH / 8;
  localparam logic [7:0]  ADDR_LAST  = 8'(ADDR_BYTES - 1);
  localparam logic [7:0]  DATA_LAST  = 8'(DATA_BYTES - 1);

  if ((AXI_ADDR_WIDTH % 8) != 0 || (AXI_DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("axis_axil_cmd_bridge: widths must be byte multiples and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WDATA, S_DRAIN,
    S_AXI_WR, S_WAIT_B, S_AXI_RD, S_WAIT_R, S_RESP
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;        // byte index within ADDR/WDATA/RESP
  logic                      is_wr_q, is_wr_d;
  logic [1:0]                tid_q, tid_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;      // write data, then read data shifted out
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      ar_valid_q, ar_valid_d;
  logic [7:0]                err_q, err_d;
  logic                      rdy_en_q;            // holds tready low for one cycle after reset
  logic                      s_hs;
  logic                      err_inc;

  assign s_hs = s_axis_tvalid && s_axis_tready;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timed;

  assign timed = (state_q inside {S_AXI_WR, S_WAIT_B, S_AXI_RD, S_WAIT_R});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (!timed || state_d != state_q) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    tid_d      = tid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    err_d      = err_q;
    err_inc    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_hs) begin
          is_wr_d = s_axis_tdata[7];
          tid_d   = s_axis_tid;
          cnt_d   = '0;
          if (s_axis_tdest != DEST_ID) begin
            // Not ours: swallow the rest of the frame silently.
            if (!s_axis_tlast) state_d = S_DRAIN;
          end else if (s_axis_tlast) begin
            err_inc = 1'b1;               // header alone is a truncated frame
          end else begin
            state_d = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        if (s_hs) begin
          addr_d = (addr_q << 8) | AXI_ADDR_WIDTH'(s_axis_tdata);
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (is_wr_q) begin
              if (s_axis_tlast) begin
                err_inc = 1'b1;
                state_d = S_IDLE;
              end else begin
                state_d = S_WDATA;
              end
            end else if (s_axis_tlast) begin
              ar_valid_d = 1'b1;
              state_d    = S_AXI_RD;
            end else begin
              err_inc = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (s_axis_tlast) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_WDATA: begin
        if (s_hs) begin
          data_d = (data_q << 8) | AXI_DATA_WIDTH'(s_axis_tdata);
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (s_axis_tlast) begin
              aw_valid_d = 1'b1;
              w_valid_d  = 1'b1;
              state_d    = S_AXI_WR;
            end else begin
              err_inc = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (s_axis_tlast) begin
            err_inc = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if (s_hs && s_axis_tlast) state_d = S_IDLE;
      end

      S_AXI_WR: begin
        // AW and W complete independently; move on once both are done.
        if (axil_aw_ready) aw_valid_d = 1'b0;
        if (axil_w_ready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) state_d = S_WAIT_B;
      end

      S_WAIT_B: begin
        if (axil_b_valid) state_d = S_IDLE;
      end

      S_AXI_RD: begin
        if (axil_ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = S_WAIT_R;
        end
      end

      S_WAIT_R: begin
        if (axil_r_valid) begin
          data_d  = axil_r_data;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (m_axis_tready) begin
          data_d = data_q << 8;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == DATA_LAST) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef BRIDGE_TIMEOUT_EN
    // A handshake landing on the final cycle wins over the watchdog.
    if (timed && to_cnt_q == TO_LAST && state_d == state_q) begin
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      ar_valid_d = 1'b0;
      err_inc    = 1'b1;
      if (state_q == S_AXI_WR || state_q == S_WAIT_B) begin
        state_d = S_IDLE;
      end else begin
        data_d  = '1;
        cnt_d   = '0;
        state_d = S_RESP;
      end
    end
`endif

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      tid_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      err_q      <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      tid_q      <= tid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      err_q      <= err_d;
      rdy_en_q   <= 1'b1;
    end
  end

  assign s_axis_tready   = rdy_en_q && (state_q inside {S_IDLE, S_ADDR, S_WDATA, S_DRAIN});

  assign m_axis_tvalid   = (state_q == S_RESP);
  assign m_axis_tdata    = data_q[AXI_DATA_WIDTH-1 -: 8];
  assign m_axis_tlast    = m_axis_tvalid && (cnt_q == DATA_LAST);
  assign m_axis_tid      = tid_q;
  assign m_axis_tdest    = 4'd0;

  assign axil_aw_addr    = addr_q;
  assign axil_aw_valid   = aw_valid_q;
  assign axil_w_data     = data_q;
  assign axil_w_strb     = '1;
  assign axil_w_valid    = w_valid_q;
  assign axil_b_ready    = (state_q == S_WAIT_B);
  assign axil_ar_addr    = addr_q;
  assign axil_ar_valid   = ar_valid_q;
  assign axil_r_ready    = (state_q == S_WAIT_R);

  assign frame_err_count = err_q;

endmodule

// File: tb/tb_axis_axil_cmd_bridge.sv
`timescale 1ns/1ps
module tb_axis_axil_cmd_bridge;

  localparam int         AW     = 16;
  localparam int         DW     = 32;
  localparam int         AB     = AW / 8;
  localparam int         DB     = DW / 8;
  localparam logic [3:0] DEST   = 4'd0;
  localparam int         TO_CYC = 16;
  localparam int         BUDGET = 300;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [3:0]    s_axis_tdest;
  logic [1:0]    s_axis_tid;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]    m_axis_tid;
  logic [3:0]    m_axis_tdest;
  logic [AW-1:0] axil_aw_addr, axil_ar_addr;
  logic          axil_aw_valid, axil_aw_ready;
  logic [DW-1:0] axil_w_data, axil_r_data;
  logic [DB-1:0] axil_w_strb;
  logic          axil_w_valid, axil_w_ready;
  logic          axil_b_valid, axil_b_ready;
  logic          axil_ar_valid, axil_ar_ready;
  logic          axil_r_valid, axil_r_ready;
  logic [7:0]    frame_err_count;

  always #5 clk = ~clk;

  axis_axil_cmd_bridge #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .DEST_ID(DEST), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdest(s_axis_tdest), .s_axis_tid(s_axis_tid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest), .m_axis_tready(m_axis_tready),
    .axil_aw_addr(axil_aw_addr), .axil_aw_valid(axil_aw_valid), .axil_aw_ready(axil_aw_ready),
    .axil_w_data(axil_w_data), .axil_w_strb(axil_w_strb), .axil_w_valid(axil_w_valid),
    .axil_w_ready(axil_w_ready), .axil_b_valid(axil_b_valid), .axil_b_ready(axil_b_ready),
    .axil_ar_addr(axil_ar_addr), .axil_ar_valid(axil_ar_valid), .axil_ar_ready(axil_ar_ready),
    .axil_r_data(axil_r_data), .axil_r_valid(axil_r_valid), .axil_r_ready(axil_r_ready),
    .frame_err_count(frame_err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- register-file model shared by slave and reference -------
  function automatic logic [31:0] mem_init(input logic [15:0] a);
    return {a, ~a} ^ 32'h5A3C_96E1;
  endfunction

  logic [31:0] slv_mem [logic [15:0]];   // what the bus slave holds
  logic [31:0] ref_mem [logic [15:0]];   // what the frames say it should hold

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;
  wr_t wr_log[$];

  // slave latency knobs (cycles from valid to ready / from request to response)
  int lat_aw = 0, lat_w = 0, lat_ar = 0, lat_b = 0, lat_r = 0;
  bit mon_en = 1'b1;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;

  // ---------------- AXI-Lite slave: decides at negedge for the next posedge -
  initial begin : slave
    int c_aw, c_w, c_ar, c_b, c_r;
    logic hs_aw, hs_w, hs_ar, hs_b, hs_r, pv_aw, pv_w, pv_ar;
    logic [15:0] aq[$];
    logic [31:0] wq[$];
    logic [3:0]  sq[$];
    logic [15:0] rq[$];
    axil_aw_ready = 0; axil_w_ready = 0; axil_ar_ready = 0;
    axil_b_valid = 0; axil_r_valid = 0; axil_r_data = '0;
    c_aw = 0; c_w = 0; c_ar = 0; c_b = 0; c_r = 0;
    {hs_aw, hs_w, hs_ar, hs_b, hs_r, pv_aw, pv_w, pv_ar} = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        axil_aw_ready = 0; axil_w_ready = 0; axil_ar_ready = 0;
        axil_b_valid = 0; axil_r_valid = 0;
        aq.delete(); wq.delete(); sq.delete(); rq.delete();
        c_aw = 0; c_w = 0; c_ar = 0; c_b = 0; c_r = 0;
        {hs_aw, hs_w, hs_ar, hs_b, hs_r, pv_aw, pv_w, pv_ar} = '0;
        continue;
      end
      if (mon_en) begin
        if (pv_aw && !hs_aw) check("aw_valid_held", axil_aw_valid, 1);
        if (hs_aw)           check("aw_valid_drop", axil_aw_valid, 0);
        if (pv_w && !hs_w)   check("w_valid_held", axil_w_valid, 1);
        if (hs_w)            check("w_valid_drop", axil_w_valid, 0);
        if (pv_ar && !hs_ar) check("ar_valid_held", axil_ar_valid, 1);
        if (hs_ar)           check("ar_valid_drop", axil_ar_valid, 0);
      end
      if (hs_b) axil_b_valid = 0;
      if (hs_r) axil_r_valid = 0;
      if (!axil_b_valid && aq.size() > 0 && wq.size() > 0) begin
        if (c_b >= lat_b) begin
          wr_t t;
          t.a = aq.pop_front(); t.d = wq.pop_front(); t.s = sq.pop_front();
          wr_log.push_back(t);
          slv_mem[t.a] = t.d;
          axil_b_valid = 1; c_b = 0;
        end else c_b++;
      end
      if (!axil_r_valid && rq.size() > 0) begin
        if (c_r >= lat_r) begin
          logic [15:0] a;
          a = rq.pop_front();
          axil_r_data  = slv_mem.exists(a) ? slv_mem[a] : mem_init(a);
          axil_r_valid = 1; c_r = 0;
        end else c_r++;
      end
      if (axil_aw_valid) begin axil_aw_ready = (c_aw >= lat_aw); c_aw++; end
      else begin axil_aw_ready = 0; c_aw = 0; end
      if (axil_w_valid) begin axil_w_ready = (c_w >= lat_w); c_w++; end
      else begin axil_w_ready = 0; c_w = 0; end
      if (axil_ar_valid) begin axil_ar_ready = (c_ar >= lat_ar); c_ar++; end
      else begin axil_ar_ready = 0; c_ar = 0; end
      hs_aw = axil_aw_valid && axil_aw_ready;
      hs_w  = axil_w_valid && axil_w_ready;
      hs_ar = axil_ar_valid && axil_ar_ready;
      hs_b  = axil_b_valid && axil_b_ready;
      hs_r  = axil_r_valid && axil_r_ready;
      if (hs_aw) begin aq.push_back(axil_aw_addr); n_aw++; end
      if (hs_w)  begin wq.push_back(axil_w_data); sq.push_back(axil_w_strb); n_w++; end
      if (hs_ar) begin rq.push_back(axil_ar_addr); n_ar++; end
      if (hs_b)  n_b++;
      if (hs_r)  n_r++;
      pv_aw = axil_aw_valid; pv_w = axil_w_valid; pv_ar = axil_ar_valid;
    end
  end

  // ---------------- reference expectations ----------------------------------
  int exp_aw = 0, exp_w = 0, exp_ar = 0, exp_b = 0, exp_r = 0, exp_err = 0;
  bit tready_alt = 1'b0;

  task automatic bump_err();
    exp_err = (exp_err == 255) ? 255 : exp_err + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_aw_valid", axil_aw_valid, 0);
    check("rst_w_valid", axil_w_valid, 0);
    check("rst_ar_valid", axil_ar_valid, 0);
    check("rst_b_ready", axil_b_ready, 0);
    check("rst_r_ready", axil_r_ready, 0);
    check("rst_w_strb", axil_w_strb, 4'hF);
    check("rst_addr", axil_aw_addr, 0);
    check("rst_wdata", axil_w_data, 0);
    check("rst_err", frame_err_count, 0);
    exp_err = 0;
    reset = 1'b0;
    #1 check("rst_tready_first", s_axis_tready, 0);
    @(negedge clk);
    check("rst_tready_after", s_axis_tready, 1);
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] d, input logic l, input logic [3:0] dst, input logic [1:0] id);
    int n = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tdest = dst; s_axis_tid = id;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) check("s_tready_timeout", 0, 1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input logic [3:0] dst, input logic [1:0] id);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], (i == b.size() - 1), dst, id);
  endtask

  task automatic collect_resp(input logic [31:0] exp, input logic [1:0] id);
    logic [31:0] e = exp;
    logic [7:0]  held = '0;
    bit          stalled = 0;
    int          got = 0, n = 0;
    while (got < DB && n < BUDGET) begin
      m_axis_tready = tready_alt ? ~m_axis_tready : 1'($urandom_range(0, 1));
      if (m_axis_tvalid) begin
        if (stalled) check("resp_stable", m_axis_tdata, held);
        if (m_axis_tready) begin
          check("resp_byte", m_axis_tdata, e[31:24]);
          check("resp_last", m_axis_tlast, (got == DB - 1));
          check("resp_tid", m_axis_tid, id);
          check("resp_tdest", m_axis_tdest, 0);
          e = e << 8; got++; stalled = 0;
        end else begin
          stalled = 1; held = m_axis_tdata;
        end
      end
      @(negedge clk); n++;
    end
    m_axis_tready = 1'b0;
    check("resp_count", got, DB);
    check("resp_no_extra", m_axis_tvalid, 0);
  endtask

  task automatic check_counts();
    check("cnt_aw", n_aw, exp_aw);
    check("cnt_w", n_w, exp_w);
    check("cnt_ar", n_ar, exp_ar);
    check("cnt_b", n_b, exp_b);
    check("cnt_r", n_r, exp_r);
    check("err_count", frame_err_count, exp_err);
  endtask

  // Classifies the frame from its length and destination, sends it, and
  // checks what the bus and the response stream must show.
  task automatic run_frame(input logic [7:0] b[$], input logic [3:0] dst, input logic [1:0] id);
    logic        rw = b[0][7];
    int          need = 1 + AB + (rw ? DB : 0);
    bit          exec = (dst == DEST) && (b.size() == need);
    logic [15:0] a = '0;
    logic [31:0] d = '0;
    int          n = 0;
    if (dst == DEST && b.size() != need) bump_err();
    if (exec) begin
      for (int i = 0; i < AB; i++) a = (a << 8) | 16'(b[1 + i]);
      if (rw) for (int i = 0; i < DB; i++) d = (d << 8) | 32'(b[1 + AB + i]);
    end
    send_frame(b, dst, id);
    if (exec && rw) begin
      exp_aw++; exp_w++; exp_b++;
      ref_mem[a] = d;
      while (n_b != exp_b && n < BUDGET) begin @(negedge clk); n++; end
      check("b_handshake", n_b, exp_b);
      if (wr_log.size() == 0) check("wr_seen", 0, 1);
      else begin
        wr_t t = wr_log.pop_front();
        check("wr_addr", t.a, a);
        check("wr_data", t.d, d);
        check("wr_strb", t.s, 4'hF);
      end
      check("wr_no_resp", m_axis_tvalid, 0);
    end else if (exec) begin
      exp_ar++; exp_r++;
      collect_resp(ref_mem.exists(a) ? ref_mem[a] : mem_init(a), id);
    end
    repeat (3) @(negedge clk);
    check_counts();
  endtask

  task automatic random_frame();
    logic [7:0]  fb[$];
    int          kind = $urandom_range(0, 9);
    logic        rw = 1'($urandom_range(0, 1));
    int          need = 1 + AB + (rw ? DB : 0);
    int          len;
    logic [3:0]  dst = DEST;
    logic [15:0] a = 16'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) a = 16'($urandom);
    if (kind < 5)      len = need;
    else if (kind < 7) len = $urandom_range(1, need - 1);
    else if (kind < 9) len = need + $urandom_range(1, 3);
    else begin len = $urandom_range(1, 8); dst = 4'($urandom_range(1, 15)); end
    fb.push_back({rw, 7'($urandom)});
    for (int i = 1; i < len; i++) begin
      if (i <= AB) fb.push_back(8'(a >> (8 * (AB - i))));
      else         fb.push_back(8'($urandom));
    end
    lat_aw = $urandom_range(0, 4); lat_w = $urandom_range(0, 4); lat_ar = $urandom_range(0, 4);
    lat_b  = $urandom_range(0, 4); lat_r = $urandom_range(0, 4);
    run_frame(fb, dst, 2'($urandom));
  endtask

  initial begin : watchdog
    #900us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] fb[$];
    int n;
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdest = '0; s_axis_tid = '0;
    m_axis_tready = 0;
    @(negedge clk);
    do_reset();

    // Plain write, slave ready at once.
    fb = {8'h80, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(fb, DEST, 2'd0);

    // Read with a known slave value and an alternating tready.
    slv_mem[16'h0020] = 32'h1234_5678;
    ref_mem[16'h0020] = 32'h1234_5678;
    tready_alt = 1'b1;
    fb = {8'h00, 8'h00, 8'h20};
    run_frame(fb, DEST, 2'd2);
    tready_alt = 1'b0;

    // W accepted three cycles after AW.
    lat_aw = 0; lat_w = 3;
    fb = {8'h80, 8'h00, 8'h24, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(fb, DEST, 2'd1);
    lat_w = 0;

    // tlast on the 2nd address byte of a write, then a good read of it back.
    fb = {8'h80, 8'h00, 8'h10};
    run_frame(fb, DEST, 2'd0);
    check("err_after_short", frame_err_count, 1);
    fb = {8'h00, 8'h00, 8'h10};
    run_frame(fb, DEST, 2'd3);

    // 6-byte read frame: drained, no read.
    fb = {8'h00, 8'h00, 8'h30, 8'h11, 8'h22, 8'h33};
    run_frame(fb, DEST, 2'd0);
    check("err_after_long", frame_err_count, 2);

    // Foreign destination: consumed without effect.
    fb = {8'h80, 8'h00, 8'h10, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(fb, 4'd5, 2'd1);

    // Reset while waiting for read data.
    lat_r = 1000;
    fb = {8'h00, 8'h00, 8'h20};
    send_frame(fb, DEST, 2'd2);
    exp_ar++;
    n = 0;
    while (!axil_r_ready && n < BUDGET) begin @(negedge clk); n++; end
    check("reached_wait_r", axil_r_ready, 1);
    repeat (2) @(negedge clk);
    do_reset();
    lat_r = 0;
    repeat (2) @(negedge clk);
    check_counts();

    for (int i = 0; i < 150; i++) random_frame();
    lat_aw = 0; lat_w = 0; lat_ar = 0; lat_b = 0; lat_r = 0;

`ifdef BRIDGE_TIMEOUT_EN
    begin : timeout_test
      int k = 0;
      mon_en = 1'b0; lat_ar = 100000;
      fb = {8'h00, 8'h00, 8'h30};
      send_frame(fb, DEST, 2'd1);
      while (axil_ar_valid && k < BUDGET) begin @(negedge clk); k++; end
      check("to_ar_cycles", k, TO_CYC);
      bump_err();
      collect_resp(32'hFFFF_FFFF, 2'd1);
      repeat (3) @(negedge clk);
      check_counts();
      lat_ar = 0; mon_en = 1'b1;
    end
`endif

    // Drive the error counter into saturation with truncated reads.
    for (int i = 0; i < 260; i++) begin
      fb = {8'h00, 8'h00};
      run_frame(fb, DEST, 2'd0);
    end
    check("err_saturated", frame_err_count, 8'hFF);

    // Bridge still works after saturation.
    fb = {8'h00, 8'h00, 8'h24};
    run_frame(fb, DEST, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
